// File: rtl/mul_seq_ctrl_if.sv
// Control/status bundle between the shift-add multiplier sequencer and its datapath.
interface mul_seq_ctrl_if #(
  parameter int unsigned WIDTH = 8
) ();
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic          start;
  logic          q_lsb;
  logic          a_lsb;
  logic          add_cout;
  logic [1:0]    a_shift;
  logic          a_d0;
  logic          a_load_sel;
  logic [1:0]    q_shift;
  logic          q_d0;
  logic          m_load;
  logic          busy;
  logic          done;
  logic [CW-1:0] step_cnt;

  modport master (
    output start, q_lsb, a_lsb, add_cout,
    input  a_shift, a_d0, a_load_sel, q_shift, q_d0, m_load, busy, done, step_cnt
  );

  modport slave (
    input  start, q_lsb, a_lsb, add_cout,
    output a_shift, a_d0, a_load_sel, q_shift, q_d0, m_load, busy, done, step_cnt
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Sequencer for a shift-add unsigned multiplier: drives A/Q/M register controls,
// holds the adder carry between the add and shift cycles, and counts bit steps.
module mul_seq_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          resetn,
  mul_seq_ctrl_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] ShHold  = 2'b00;
  localparam logic [1:0] ShRight = 2'b01;
  localparam logic [1:0] ShLoad  = 2'b11;

  typedef enum logic [2:0] {StIdle, StLoad, StStep, StShift, StDone} state_e;

  state_e        state_q, state_d;
  logic          c_q, c_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [1:0] a_shift, q_shift;
  logic       a_d0, a_load_sel, q_d0, m_load, busy, done;
  logic       last_step;

  assign last_step = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    c_d        = c_q;
    cnt_d      = cnt_q;
    a_shift    = ShHold;
    q_shift    = ShHold;
    a_d0       = 1'b0;
    a_load_sel = 1'b0;
    q_d0       = 1'b0;
    m_load     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StLoad;
      end
      StLoad: begin
        busy    = 1'b1;
        a_shift = ShLoad;
        q_shift = ShLoad;
        m_load  = 1'b1;
        c_d     = 1'b0;
        cnt_d   = '0;
        state_d = StStep;
      end
      StStep: begin
        busy = 1'b1;
        if (bus.q_lsb) begin
          a_shift    = ShLoad;
          a_load_sel = 1'b1;
          c_d        = bus.add_cout;
          state_d    = StShift;
        end else begin
          a_shift = ShRight;
          q_shift = ShRight;
          q_d0    = bus.a_lsb;
          cnt_d   = cnt_q + CW'(1);
          state_d = last_step ? StDone : StStep;
        end
      end
      StShift: begin
        // Carry saved from the add cycle becomes the new A[msb].
        busy    = 1'b1;
        a_shift = ShRight;
        a_d0    = c_q;
        q_shift = ShRight;
        q_d0    = bus.a_lsb;
        c_d     = 1'b0;
        cnt_d   = cnt_q + CW'(1);
        state_d = last_step ? StDone : StStep;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.a_shift    = a_shift;
  assign bus.a_d0       = a_d0;
  assign bus.a_load_sel = a_load_sel;
  assign bus.q_shift    = q_shift;
  assign bus.q_d0       = q_d0;
  assign bus.m_load     = m_load;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.step_cnt   = cnt_q;
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench: A/Q/M registers and adder modelled around the controller; expected products
// and done timing come from plain arithmetic and are checked by a scoreboard monitor.
module tb_mul_seq_ctrl;
  localparam int unsigned W = 8;

  typedef struct {
    logic [15:0] prod;
    int unsigned scyc;
    int unsigned dcyc;
    int unsigned adds;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic [7:0] a_reg, q_reg, m_reg;
  logic [7:0] mcand, mplier;
  logic [8:0] add_sum;

  exp_t sb[$];

  mul_seq_ctrl_if #(.WIDTH(W)) bus ();

  mul_seq_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External datapath: shift registers and adder.
  assign add_sum      = {1'b0, a_reg} + {1'b0, m_reg};
  assign bus.q_lsb    = q_reg[0];
  assign bus.a_lsb    = a_reg[0];
  assign bus.add_cout = add_sum[8];

  always @(posedge clk) begin
    if (!resetn) begin
      a_reg <= '0;
      q_reg <= '0;
      m_reg <= '0;
    end else begin
      case (bus.a_shift)
        2'b11:   a_reg <= bus.a_load_sel ? add_sum[7:0] : 8'h00;
        2'b01:   a_reg <= {bus.a_d0, a_reg[7:1]};
        default: a_reg <= a_reg;
      endcase
      case (bus.q_shift)
        2'b11:   q_reg <= mplier;
        2'b01:   q_reg <= {bus.q_d0, q_reg[7:1]};
        default: q_reg <= q_reg;
      endcase
      if (bus.m_load) m_reg <= mcand;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor / scoreboard.
  logic        pend = 1'b0;
  logic        pend_c = 1'b0;
  logic        hold_chk = 1'b0;
  int unsigned adds = 0;
  logic        exp_busy;
  exp_t        e;

  always @(negedge clk) begin
    if (!resetn) begin
      pend     = 1'b0;
      hold_chk = 1'b0;
    end else begin
      exp_busy = (sb.size() != 0) && (cyc >= sb[0].scyc + 1) && (cyc + 1 <= sb[0].dcyc);
      check("busy", 32'(bus.busy), 32'(exp_busy));
      if (hold_chk) begin
        check("step_cnt_hold", 32'(bus.step_cnt), W);
        hold_chk = 1'b0;
      end
      if (pend) begin
        check("shift_after_add", 32'({bus.a_shift, bus.a_d0}), 32'({2'b01, pend_c}));
        pend = 1'b0;
      end
      if (bus.m_load) adds = 0;
      if (bus.a_shift == 2'b11 && bus.a_load_sel) begin
        adds++;
        pend   = 1'b1;
        pend_c = add_sum[8];
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected done=0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.dcyc);
          check("product", 32'({a_reg, q_reg}), 32'(e.prod));
          check("step_cnt_final", 32'(bus.step_cnt), W);
          check("add_cycles", adds, e.adds);
          hold_chk = 1'b1;
        end
      end
    end
  end

  // Stimulus: called #1 after a rising edge, in the cycle the start is to be accepted.
  task automatic launch(input logic [7:0] m, input logic [7:0] mult, output int unsigned dc);
    exp_t x;
    mcand     = m;
    mplier    = mult;
    bus.start = 1'b1;
    x.prod    = {8'h00, m} * {8'h00, mult};
    x.adds    = 32'($countones(mult));
    x.scyc    = cyc;
    x.dcyc    = cyc + 2 + W + x.adds;
    sb.push_back(x);
    dc = x.dcyc;
  endtask

  task automatic wait_until(input int unsigned target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_one(input logic [7:0] m, input logic [7:0] mult, input int unsigned gap);
    int unsigned dc;
    launch(m, mult, dc);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_until(dc + 1 + gap);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_a_shift"}, 32'(bus.a_shift), 0);
    check({tag, "_q_shift"}, 32'(bus.q_shift), 0);
    check({tag, "_m_load"}, 32'(bus.m_load), 0);
    check({tag, "_step_cnt"}, 32'(bus.step_cnt), 0);
  endtask

  initial begin
    int unsigned dc, c0;
    bus.start = 1'b0;
    mcand     = '0;
    mplier    = '0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    check_idle_outputs("reset");

    @(posedge clk);
    #1;
    run_one(8'd13, 8'd11, 0);
    run_one(8'hFF, 8'hFF, 0);
    run_one(8'h5A, 8'h00, 1);

    // Start held through a whole run; second run accepted in the IDLE after DONE.
    launch(8'h03, 8'h81, dc);
    wait_until(dc + 1);
    launch(8'h07, 8'h05, dc);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_until(dc + 2);

    // Reset in cycle 5 of a run.
    c0 = cyc;
    launch(8'hFF, 8'hFF, dc);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_until(c0 + 5);
    resetn = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    check_idle_outputs("midreset");
    run_one(8'd2, 8'd3, 0);

    // Back-to-back.
    run_one(8'd1, 8'd1, 0);
    run_one(8'h80, 8'h02, 0);

    for (int i = 0; i < 12; i++) begin
      run_one(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              32'($urandom_range(0, 2)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
